instr_sequencer: RTL and testbench
==================================

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have parameter PAUSE_CYCLES, default 16, giving the stall length of a PAUSE hint in cycles (legal range 1..255).
REQ-002 SHALL have port clk, input, 1 bit: the single clock.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port instr_req, output, 1 bit: instruction fetch request.
REQ-005 SHALL have port instr_ack, input, 1 bit: fetch data valid.
REQ-006 SHALL have port ir_we, output, 1 bit: load the instruction register.
REQ-007 SHALL have ports branch, load_pc, alu_sel, reg_w, data_r, data_w and pause, each an input of 1 bit, carrying the decoder flags.
REQ-008 SHALL have port branch_taken, input, 1 bit: ALU compare result.
REQ-009 SHALL have port alu_en, output, 1 bit: ALU operand/result capture enable.
REQ-010 SHALL have port data_req, output, 1 bit: data bus request.
REQ-011 SHALL have port data_we, output, 1 bit: data bus write qualifier.
REQ-012 SHALL have port data_ack, input, 1 bit: data bus done.
REQ-013 SHALL have port reg_we, output, 1 bit: register file write strobe.
REQ-014 SHALL have port pc_we, output, 1 bit: PC update strobe.
REQ-015 SHALL have port pc_sel, output, 1 bit: 0 selects pc+4, 1 selects the computed target.
REQ-016 SHALL have port halt_req, input, 1 bit: stop at the next instruction boundary.
REQ-017 SHALL have port halted, output, 1 bit: core is parked.
REQ-018 SHALL have port retired, output, 32 bits: retired-instruction counter.
REQ-019 SHALL have port state, output, 3 bits: current FSM state, for debug.

Function
REQ-020 SHALL implement the states IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, PAUSE=6 and HALT=7.
REQ-021 SHALL derive every output from registered state only, as Moore outputs; retired SHALL be a register.
REQ-022 SHALL go IDLE->FETCH unconditionally.
REQ-023 SHALL, in FETCH, hold instr_req=1 until instr_ack; the ack cycle SHALL pulse ir_we=1 and go to DECODE.
REQ-024 SHALL spend exactly 1 cycle in DECODE and then go to PAUSE if pause=1 (see Configuration), else to EXEC.
REQ-025 SHALL spend 1 cycle in EXEC with alu_en=alu_sel, then go to MEM if data_r or data_w is 1, else to WB.
REQ-026 SHALL, in MEM, hold data_req=1 and data_we=data_w until data_ack; data_ack in the same cycle data_req first rises SHALL be accepted; on the ack go to WB.
REQ-027 SHALL spend 1 cycle in WB with pc_we=1, reg_we=reg_w, and pc_sel=load_pc OR (branch AND branch_taken); retired SHALL increment modulo 2^32 (0xFFFFFFFF wraps to 0).
REQ-028 SHALL, on leaving WB, go to HALT if halt_req=1, else to FETCH.
REQ-029 SHALL, in HALT, hold halted=1 and all strobes at 0, and return to FETCH the cycle after halt_req=0.
REQ-030 SHALL ignore halt_req outside WB, so that an instruction is never split.
REQ-031 SHALL sample decoder flags only in the state that consumes them; flag changes in other states SHALL have no effect.
REQ-032 SHALL minimum-latency an instruction as follows: ALU-type 4 cycles (FETCH with same-cycle ack, DECODE, EXEC, WB); load/store 5 cycles plus the data wait.

Reset
REQ-033 SHALL, while rst_n=0, force state=IDLE, retired=0 and the pause counter to 0, and drive every output to 0.
REQ-034 SHALL abandon any outstanding fetch or data request immediately when rst_n is asserted mid-operation, driving instr_req and data_req to 0 asynchronously.
REQ-035 SHALL enter FETCH on the second rising clk edge after rst_n deasserts.

Configuration
REQ-036 SHALL, with ZIHINTPAUSE_EN defined, on DECODE with pause=1, load the counter with PAUSE_CYCLES-1 and enter PAUSE.
REQ-037 SHALL, with ZIHINTPAUSE_EN defined, decrement the counter each PAUSE cycle, go to WB when it reaches 0, and use pc_sel=0, reg_we=0 in that WB.
REQ-038 SHALL, with ZIHINTPAUSE_EN undefined, ignore the pause input, never enter PAUSE, omit the counter, and run PAUSE encodings as FENCE-NOPs: DECODE->EXEC->WB.

Verification
REQ-039 SHALL cover reset: pulse rst_n low mid-MEM with data_req=1 -> data_req=0 the same cycle, state=0, retired=0; state=1 two edges after release.
REQ-040 SHALL cover ALU instruction with instr_ack tied 1: alu_sel=1, reg_w=1 -> state sequence 1,2,3,5,1; reg_we and pc_we high only in state 5; retired +1.
REQ-041 SHALL cover load with data_ack delayed 3 cycles: data_r=1 -> data_req held 4 cycles, data_we=0, reg_we=1 in the following WB.
REQ-042 SHALL cover taken branch: branch=1, branch_taken=1 -> pc_sel=1 in WB; with branch_taken=0 -> pc_sel=0; reg_we=0 in both.
REQ-043 SHALL cover PAUSE with PAUSE_CYCLES=4 and the macro defined: exactly 4 cycles in state 6, then WB with pc_sel=0; with the macro undefined: no state 6, DECODE->EXEC->WB.
REQ-044 SHALL cover halt and wrap: halt_req=1 asserted during EXEC -> HALT entered after WB; release -> FETCH next cycle; preload retired=0xFFFFFFFF and retire one instruction -> 0.

Source files
------------

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: fetch, decode, execute, memory, writeback and halt parking.
// Defining ZIHINTPAUSE_EN enables the PAUSE hint stall of PAUSE_CYCLES cycles.
`timescale 1ns/1ps
module instr_sequencer #(
  parameter int unsigned PAUSE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        instr_req,
  input  logic        instr_ack,
  output logic        ir_we,
  input  logic        branch,
  input  logic        load_pc,
  input  logic        alu_sel,
  input  logic        reg_w,
  input  logic        data_r,
  input  logic        data_w,
  input  logic        pause,
  input  logic        branch_taken,
  output logic        alu_en,
  output logic        data_req,
  output logic        data_we,
  input  logic        data_ack,
  output logic        reg_we,
  output logic        pc_we,
  output logic        pc_sel,
  input  logic        halt_req,
  output logic        halted,
  output logic [31:0] retired,
  output logic [2:0]  state
);

  localparam int unsigned ST_W  = 3;
  localparam int unsigned RET_W = 32;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_PAUSE  = 3'd6,
    ST_HALT   = 3'd7
  } state_e;

  state_e             state_q, state_d;
  logic               start_q;
  logic               branch_q, load_pc_q, reg_w_q, data_r_q, data_w_q, taken_q;
  logic [RET_W-1:0]   retired_q, retired_d;
  logic               instr_req_q, instr_req_d;
  logic               alu_en_q, alu_en_d;
  logic               data_req_q, data_req_d;
  logic               data_we_q, data_we_d;
  logic               reg_we_q, reg_we_d;
  logic               pc_we_q, pc_we_d;
  logic               pc_sel_q, pc_sel_d;
  logic               halted_q, halted_d;
  logic               taken_now;
  logic               wb_from_pause;

`ifdef ZIHINTPAUSE_EN
  localparam int unsigned CNT_W = 8;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // Pause counter: loaded on a PAUSE decode, counts down to zero while stalled
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_DECODE && pause) begin
      cnt_d = CNT_W'(PAUSE_CYCLES - 1);
    end else if (state_q == ST_PAUSE && cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic               unused_pause;
  logic [7:0]         unused_pause_len;
  assign unused_pause     = pause;
  assign unused_pause_len = 8'(PAUSE_CYCLES);
`endif

  // State, latched decoder flags, retire counter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      start_q     <= 1'b0;
      retired_q   <= '0;
      branch_q    <= 1'b0;
      load_pc_q   <= 1'b0;
      reg_w_q     <= 1'b0;
      data_r_q    <= 1'b0;
      data_w_q    <= 1'b0;
      taken_q     <= 1'b0;
      instr_req_q <= 1'b0;
      alu_en_q    <= 1'b0;
      data_req_q  <= 1'b0;
      data_we_q   <= 1'b0;
      reg_we_q    <= 1'b0;
      pc_we_q     <= 1'b0;
      pc_sel_q    <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_q     <= 1'b1;
      retired_q   <= retired_d;
      if (state_q == ST_DECODE) begin
        branch_q  <= branch;
        load_pc_q <= load_pc;
        reg_w_q   <= reg_w;
        data_r_q  <= data_r;
        data_w_q  <= data_w;
      end
      if (state_q == ST_EXEC) begin
        taken_q   <= branch_taken;
      end
      instr_req_q <= instr_req_d;
      alu_en_q    <= alu_en_d;
      data_req_q  <= data_req_d;
      data_we_q   <= data_we_d;
      reg_we_q    <= reg_we_d;
      pc_we_q     <= pc_we_d;
      pc_sel_q    <= pc_sel_d;
      halted_q    <= halted_d;
    end
  end

  // Next-state logic; IDLE waits one extra edge so FETCH starts on the second edge after reset
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start_q) state_d = ST_FETCH;
      ST_FETCH:  if (instr_ack) state_d = ST_DECODE;
`ifdef ZIHINTPAUSE_EN
      ST_DECODE: state_d = pause ? ST_PAUSE : ST_EXEC;
      ST_PAUSE:  if (cnt_q == '0) state_d = ST_WB;
`else
      ST_DECODE: state_d = ST_EXEC;
      ST_PAUSE:  state_d = ST_FETCH;
`endif
      ST_EXEC:   state_d = (data_r_q || data_w_q) ? ST_MEM : ST_WB;
      ST_MEM:    if (data_ack) state_d = ST_WB;
      ST_WB:     state_d = halt_req ? ST_HALT : ST_FETCH;
      ST_HALT:   if (!halt_req) state_d = ST_FETCH;
      default:   state_d = ST_IDLE;
    endcase
  end

  assign taken_now     = (state_q == ST_EXEC) ? branch_taken : taken_q;
  assign wb_from_pause = (state_q == ST_PAUSE);
  assign retired_d     = (state_q == ST_WB) ? retired_q + RET_W'(1) : retired_q;

  // Output decode from the state being entered, so each strobe is a flop aligned with its state
  always_comb begin
    instr_req_d = 1'b0;
    alu_en_d    = 1'b0;
    data_req_d  = 1'b0;
    data_we_d   = 1'b0;
    reg_we_d    = 1'b0;
    pc_we_d     = 1'b0;
    pc_sel_d    = 1'b0;
    halted_d    = 1'b0;
    case (state_d)
      ST_FETCH: instr_req_d = 1'b1;
      ST_EXEC:  alu_en_d    = alu_sel;
      ST_MEM: begin
        data_req_d = 1'b1;
        data_we_d  = data_w_q;
      end
      ST_WB: begin
        pc_we_d = 1'b1;
        if (!wb_from_pause) begin
          reg_we_d = reg_w_q;
          pc_sel_d = load_pc_q | (branch_q & taken_now);
        end
      end
      ST_HALT:  halted_d = 1'b1;
      default:  ;
    endcase
  end

  // IR load must coincide with the fetch data beat, so it is the one strobe qualified by the ack
  assign ir_we     = (state_q == ST_FETCH) && instr_ack;

  assign instr_req = instr_req_q;
  assign alu_en    = alu_en_q;
  assign data_req  = data_req_q;
  assign data_we   = data_we_q;
  assign reg_we    = reg_we_q;
  assign pc_we     = pc_we_q;
  assign pc_sel    = pc_sel_q;
  assign halted    = halted_q;
  assign retired   = retired_q;
  assign state     = state_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: expected writeback records queued per instruction,
// popped and compared whenever the DUT sits in WB; traces and handshakes checked per instruction.
`timescale 1ns/1ps
module tb_instr_sequencer;

  localparam int unsigned PAUSE_LEN = 4;
  localparam logic [6:0] F_BR  = 7'b1000000;
  localparam logic [6:0] F_LPC = 7'b0100000;
  localparam logic [6:0] F_ALU = 7'b0010000;
  localparam logic [6:0] F_RW  = 7'b0001000;
  localparam logic [6:0] F_DR  = 7'b0000100;
  localparam logic [6:0] F_DW  = 7'b0000010;
  localparam logic [6:0] F_PS  = 7'b0000001;

  logic        clk, rst_n;
  logic        instr_req, instr_ack, ir_we;
  logic        branch, load_pc, alu_sel, reg_w, data_r, data_w, pause, branch_taken;
  logic        alu_en, data_req, data_we, data_ack, reg_we, pc_we, pc_sel;
  logic        halt_req, halted;
  logic [31:0] retired;
  logic [2:0]  state;

  instr_sequencer #(.PAUSE_CYCLES(PAUSE_LEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_req(instr_req), .instr_ack(instr_ack), .ir_we(ir_we),
    .branch(branch), .load_pc(load_pc), .alu_sel(alu_sel), .reg_w(reg_w),
    .data_r(data_r), .data_w(data_w), .pause(pause), .branch_taken(branch_taken),
    .alu_en(alu_en), .data_req(data_req), .data_we(data_we), .data_ack(data_ack),
    .reg_we(reg_we), .pc_we(pc_we), .pc_sel(pc_sel),
    .halt_req(halt_req), .halted(halted), .retired(retired), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        reg_we;
    logic        pc_sel;
    logic [31:0] retired;
  } wb_exp_t;

  wb_exp_t     sb_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] model_ret;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_flags(input logic [6:0] f);
    {branch, load_pc, alu_sel, reg_w, data_r, data_w, pause} = f;
  endtask

  function automatic logic [63:0] tr_add(input logic [63:0] t, input logic [3:0] s);
    return {t[59:0], s};
  endfunction

  // Writeback monitor: every WB cycle consumes one expected record
  initial begin
    wb_exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && state == 3'd5) begin
        if (sb_q.size() == 0) begin
          check_eq("wb_unexpected", 64'(1), 64'(0));
        end else begin
          e = sb_q.pop_front();
          check_eq("wb_pc_we", 64'(pc_we), 64'(1));
          check_eq("wb_reg_we", 64'(reg_we), 64'(e.reg_we));
          check_eq("wb_pc_sel", 64'(pc_sel), 64'(e.pc_sel));
          check_eq("wb_retired", 64'(retired), 64'(e.retired));
        end
      end
    end
  end

  // Runs one instruction starting at a negedge where the DUT is in FETCH
  task automatic run_instr(input logic [6:0] f, input logic tk, input int ack_dly,
                           input int mem_dly, input logic hlt);
    logic        dr, dw, alu, pause_path, done;
    logic [63:0] exp_tr, got_tr;
    int          n, fetch_n, mem_n, dreq_n, req_err, strobe_err, ack_err;
    wb_exp_t     e;
    logic [2:0]  st;
    alu = f[4]; dr = f[2]; dw = f[1];
`ifdef ZIHINTPAUSE_EN
    pause_path = f[0];
`else
    pause_path = 1'b0;
`endif
    exp_tr = '0;
    for (int i = 0; i <= ack_dly; i++) exp_tr = tr_add(exp_tr, 4'd1);
    exp_tr = tr_add(exp_tr, 4'd2);
    if (pause_path) begin
      for (int i = 0; i < int'(PAUSE_LEN); i++) exp_tr = tr_add(exp_tr, 4'd6);
    end else begin
      exp_tr = tr_add(exp_tr, 4'd3);
      if (dr || dw) for (int i = 0; i <= mem_dly; i++) exp_tr = tr_add(exp_tr, 4'd4);
    end
    exp_tr = tr_add(exp_tr, 4'd5);
    e.reg_we  = pause_path ? 1'b0 : f[3];
    e.pc_sel  = pause_path ? 1'b0 : (f[5] | (f[6] & tk));
    e.retired = model_ret;
    sb_q.push_back(e);

    drive_flags((ack_dly == 0) ? f : ~f);
    branch_taken = tk;
    instr_ack = (ack_dly == 0);
    data_ack = 1'b0;
    halt_req = 1'b0;
    got_tr = '0; done = 1'b0; n = 0; fetch_n = 0; mem_n = 0; dreq_n = 0;
    req_err = 0; strobe_err = 0; ack_err = 0;
    while (!done && n < 64) begin
      st = state;
      got_tr = {got_tr[59:0], 1'b0, st};
      if (st != 3'd5 && (pc_we || reg_we)) strobe_err++;
      if (instr_req !== (st == 3'd1)) req_err++;
      if (data_req !== (st == 3'd4)) req_err++;
      if (data_we !== (st == 3'd4 && dw)) req_err++;
      if (alu_en !== (st == 3'd3 && alu)) req_err++;
      if (halted !== 1'b0) req_err++;
      if (data_req) dreq_n++;
      case (st)
        3'd1: begin
          if (fetch_n == ack_dly) begin
            drive_flags(f);
            instr_ack = 1'b1;
            #1 if (ir_we !== 1'b1) ack_err++;
          end else begin
            instr_ack = 1'b0;
            #1 if (ir_we !== 1'b0) ack_err++;
          end
          fetch_n++;
        end
        3'd2: if (ack_dly != 0) instr_ack = 1'b0;
        3'd3: if (hlt) halt_req = 1'b1;
        3'd4: begin
          data_ack = (mem_n == mem_dly);
          mem_n++;
        end
        3'd5: done = 1'b1;
        default: ;
      endcase
      n++;
      @(negedge clk);
    end
    data_ack = 1'b0;
    check_eq("instr_done", 64'(done), 64'(1));
    check_eq("state_trace", got_tr, exp_tr);
    check_eq("req_levels", 64'(req_err), 64'(0));
    check_eq("strobes_outside_wb", 64'(strobe_err), 64'(0));
    check_eq("ir_we_pulse", 64'(ack_err), 64'(0));
    check_eq("data_req_cycles", 64'(dreq_n),
             64'((!pause_path && (dr || dw)) ? mem_dly + 1 : 0));
    model_ret = model_ret + 32'd1;
    check_eq("retired_after", 64'(retired), 64'(model_ret));
    check_eq("state_after_wb", 64'(state), 64'(hlt ? 3'd7 : 3'd1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; instr_ack = 1'b0; data_ack = 1'b0; halt_req = 1'b0;
    branch_taken = 1'b0; drive_flags(7'd0);
    model_ret = 32'd0;
    repeat (3) @(negedge clk);
    check_eq("rst_state", 64'(state), 64'(0));
    check_eq("rst_retired", 64'(retired), 64'(0));
    check_eq("rst_outputs", 64'({instr_req, ir_we, alu_en, data_req, data_we, reg_we,
                                 pc_we, pc_sel, halted}), 64'(0));
    rst_n = 1'b1;
    @(posedge clk); #1 check_eq("rel_edge1_state", 64'(state), 64'(0));
    @(posedge clk); #1 check_eq("rel_edge2_state", 64'(state), 64'(1));
    @(negedge clk);

    run_instr(F_ALU | F_RW, 1'b0, 0, 0, 1'b0);          // ALU, ack tied high
    run_instr(F_ALU | F_RW, 1'b0, 2, 0, 1'b0);          // ALU, delayed ack, scrambled flags in FETCH
    run_instr(F_DR | F_RW, 1'b0, 0, 3, 1'b0);           // load, data ack after 3 cycles
    run_instr(F_DW, 1'b0, 1, 0, 1'b0);                  // store, same-cycle data ack
    run_instr(F_BR | F_ALU, 1'b1, 0, 0, 1'b0);          // branch taken
    run_instr(F_BR | F_ALU, 1'b0, 0, 0, 1'b0);          // branch not taken
    run_instr(F_LPC | F_RW, 1'b0, 0, 0, 1'b0);          // jump-and-link
    run_instr(F_DR | F_BR | F_RW, 1'b1, 0, 2, 1'b0);    // taken flag carried through MEM
`ifdef ZIHINTPAUSE_EN
    run_instr(F_PS | F_RW | F_LPC, 1'b0, 0, 0, 1'b0);   // PAUSE stall, WB suppresses writes
`else
    run_instr(F_PS, 1'b0, 0, 0, 1'b0);                  // PAUSE runs as a NOP
`endif

    // Reset in the middle of a data access
    drive_flags(F_DR); instr_ack = 1'b1; data_ack = 1'b0;
    for (int i = 0; i < 10 && state != 3'd4; i++) @(negedge clk);
    check_eq("mid_mem_state", 64'(state), 64'(4));
    check_eq("mid_mem_data_req", 64'(data_req), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_data_req", 64'(data_req), 64'(0));
    check_eq("async_instr_req", 64'(instr_req), 64'(0));
    check_eq("async_state", 64'(state), 64'(0));
    check_eq("async_retired", 64'(retired), 64'(0));
    model_ret = 32'd0;
    drive_flags(7'd0); instr_ack = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1 check_eq("rel2_edge1_state", 64'(state), 64'(0));
    @(posedge clk); #1 check_eq("rel2_edge2_state", 64'(state), 64'(1));
    @(negedge clk);

    // Halt requested during EXEC, parks after WB
    run_instr(F_ALU | F_RW, 1'b0, 1, 0, 1'b1);
    instr_ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check_eq("halt_halted", 64'(halted), 64'(1));
      check_eq("halt_strobes", 64'({instr_req, ir_we, alu_en, data_req, reg_we, pc_we}),
               64'(0));
      @(negedge clk);
    end
    halt_req = 1'b0;
    @(negedge clk);
    check_eq("halt_release_state", 64'(state), 64'(1));
    check_eq("halt_release_halted", 64'(halted), 64'(0));

    // Retire counter wrap from all-ones
    force dut.retired_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.retired_q;
    model_ret = 32'hFFFF_FFFF;
    run_instr(F_ALU, 1'b0, 0, 0, 1'b0);

    check_eq("scoreboard_empty", 64'(sb_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
